// File: rtl/k2mm_ctrl_pkg.sv
// Shared types and helpers for the k2mm run controller.
// Holds the controller state enum, nibble-count helpers and the checksum fold.
// No ports; imported by k2mm_run_ctrl and nibble_serializer.
package k2mm_ctrl_pkg;

  typedef enum logic [2:0] {
    DELAY  = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    REPORT = 3'd4,
    HALT   = 3'd5
  } k2mm_state_e;

  localparam int NIB_W      = 4;
  // Widest word the checksum fold handles; DATA_W must not exceed this.
  localparam int MAX_FOLD_W = 64;

  // Number of report nibbles a field of width w occupies.
  function automatic int nib_cnt(input int w);
    return w / NIB_W;
  endfunction

  // chk <- rotl(chk, 1) ^ din over the low w bits (upper bits stay zero).
  function automatic logic [MAX_FOLD_W-1:0] chk_fold(input logic [MAX_FOLD_W-1:0] chk,
                                                     input logic [MAX_FOLD_W-1:0] din,
                                                     input int                    w);
    logic [MAX_FOLD_W-1:0] rot;
    rot = '0;
    for (int i = 0; i < MAX_FOLD_W; i++) begin
      if (i < w) rot[i] = chk[(i + w - 1) % w];
    end
    return rot ^ din;
  endfunction

endpackage

// File: rtl/k2mm_run_ctrl_nibble_serializer.sv
// Shifts a loaded snapshot word out 4 bits per cycle, MSB nibble first.
// Latency: first nibble one cycle after the load cycle; one nibble per cycle after that.
// Ports: load/word in; data_out/data_valid out; done marks the last valid nibble.
module nibble_serializer
  import k2mm_ctrl_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] word,
  output logic [3:0]   data_out,
  output logic         data_valid,
  output logic         done
);

  localparam int NIBS  = W / NIB_W;
  localparam int CNT_W = $clog2(NIBS + 1);

  logic [W-1:0]     sreg;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      cnt        <= '0;
      data_out   <= 4'h0;
      data_valid <= 1'b0;
    end else if (load) begin
      sreg       <= word;
      cnt        <= CNT_W'(NIBS);
      data_out   <= 4'h0;
      data_valid <= 1'b0;
    end else if (cnt != '0) begin
      data_out   <= sreg[W-1 -: 4];
      data_valid <= 1'b1;
      sreg       <= sreg << NIB_W;
      cnt        <= cnt - CNT_W'(1);
    end else begin
      data_out   <= 4'h0;
      data_valid <= 1'b0;
    end
  end

  // The counter has already reached zero while the final nibble is on the pins.
  assign done = data_valid && (cnt == '0);

endmodule

// File: rtl/k2mm_run_ctrl.sv
// Run controller: drives ap_ctrl_hs for NUM_RUNS back-to-back kernel runs, checksums E_out, then reports.
// Ports: kern_start/ready/done handshake, E_out tap, probe_out window flag, data_out/data_valid nibble report.
// Optional K2MM_CYCLE_REPORT_EN: builds the saturating cycle counter and appends it to the report.
module k2mm_run_ctrl
  import k2mm_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_RUNS  = 1000,
  parameter int START_DLY = 256,
  parameter int CYC_W     = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  output logic              kern_start,
  input  logic              kern_ready,
  input  logic              kern_done,
  input  logic              E_out_write,
  input  logic [DATA_W-1:0] E_out_din,
  output logic              probe_out,
  output logic [3:0]        data_out,
  output logic              data_valid
);

  localparam int RUN_W    = $clog2(NUM_RUNS + 1);
  localparam int DLY_W    = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;
  // DELAY lasts START_DLY cycles (at least one, as it is the reset state).
  localparam int DLY_LAST = (START_DLY > 0) ? START_DLY - 1 : 0;
  localparam int CHK_NIBS = nib_cnt(DATA_W);
  localparam int CYC_NIBS = nib_cnt(CYC_W);
`ifdef K2MM_CYCLE_REPORT_EN
  localparam bit CYC_EN   = 1'b1;
`else
  localparam bit CYC_EN   = 1'b0;
`endif
  localparam int RPT_W    = NIB_W * (CHK_NIBS + (CYC_EN ? CYC_NIBS : 0));

  k2mm_state_e       state, nxt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [DATA_W-1:0] chk, chk_nxt, chk_wr;
  logic [RPT_W-1:0]  rpt_word;
  logic              rpt_load;
  logic              ser_done;

  always_comb begin
    nxt      = state;
    rpt_load = 1'b0;
    case (state)
      DELAY:  if (dly_cnt == DLY_W'(DLY_LAST)) nxt = START;
      START:  if (kern_ready) nxt = kern_done ? NEXT : WAIT;
      WAIT:   if (kern_done) nxt = NEXT;
      NEXT: begin
        if (int'(run_cnt) + 1 < NUM_RUNS) begin
          nxt = START;
        end else begin
          nxt      = REPORT;
          rpt_load = 1'b1;
        end
      end
      REPORT: if (ser_done) nxt = HALT;
      HALT:   nxt = HALT;
      default: nxt = DELAY;
    endcase
  end

  always_comb begin
    chk_nxt = DATA_W'(chk_fold(MAX_FOLD_W'(chk), MAX_FOLD_W'(E_out_din), DATA_W));
    // Value chk takes at this edge, so the snapshot includes a write in the final NEXT cycle.
    chk_wr  = E_out_write ? chk_nxt : chk;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= DELAY;
      dly_cnt    <= '0;
      run_cnt    <= '0;
      chk        <= '0;
      kern_start <= 1'b0;
      probe_out  <= 1'b0;
    end else begin
      state      <= nxt;
      kern_start <= (nxt == START);
      if (state == DELAY) dly_cnt <= dly_cnt + DLY_W'(1);
      if (state == NEXT) run_cnt <= run_cnt + RUN_W'(1);
      if (E_out_write && state != HALT) chk <= chk_nxt;
      // Only DELAY->START is a first entry; the window closes on REPORT entry.
      if (state == DELAY && nxt == START) probe_out <= 1'b1;
      else if (rpt_load) probe_out <= 1'b0;
    end
  end

`ifdef K2MM_CYCLE_REPORT_EN
  logic [CYC_W-1:0] cyc_cnt, cyc_inc;

  // Saturating increment; the snapshot uses cyc_inc so the final NEXT cycle is counted.
  assign cyc_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_W'(1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cyc_cnt <= '0;
    end else if (state == START || state == WAIT || state == NEXT) begin
      cyc_cnt <= cyc_inc;
    end
  end

  assign rpt_word = {chk_wr, cyc_inc};
`else
  assign rpt_word = chk_wr;
`endif

  nibble_serializer #(
    .W (RPT_W)
  ) u_ser (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .load       (rpt_load),
    .word       (rpt_word),
    .data_out   (data_out),
    .data_valid (data_valid),
    .done       (ser_done)
  );

endmodule

// File: tb/tb_k2mm_run_ctrl.sv
// Directed bench for k2mm_run_ctrl with a behavioural ap_ctrl_hs kernel and a nibble scoreboard.
// Covers reset values, start delay, run gaps, same-cycle ready/done, mid-run reset and the report.
// K2MM_CYCLE_REPORT_EN selects whether cycle-count nibbles are expected after the checksum.
module tb_k2mm_run_ctrl;

  localparam int DATA_W    = 32;
  localparam int CYC_W     = 32;
  localparam int NUM_RUNS  = 3;
  localparam int START_DLY = 4;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              kern_start;
  logic              kern_ready;
  logic              kern_done;
  logic              E_out_write;
  logic [DATA_W-1:0] E_out_din;
  logic              probe_out;
  logic [3:0]        data_out;
  logic              data_valid;

  k2mm_run_ctrl #(
    .DATA_W    (DATA_W),
    .NUM_RUNS  (NUM_RUNS),
    .START_DLY (START_DLY),
    .CYC_W     (CYC_W)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .kern_start  (kern_start),
    .kern_ready  (kern_ready),
    .kern_done   (kern_done),
    .E_out_write (E_out_write),
    .E_out_din   (E_out_din),
    .probe_out   (probe_out),
    .data_out    (data_out),
    .data_valid  (data_valid)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          probe_cnt = 0;
  int          rise_cnt = 0;
  logic        ks_prev  = 1'b0;
  logic [31:0] chk_m    = '0;
  logic [3:0]  exp_q[$];

  function automatic logic [31:0] fold(input logic [31:0] c, input logic [31:0] w);
    return {c[30:0], c[31]} ^ w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every wait goes through here so the window/rise monitors see each cycle exactly once.
  task automatic tick();
    @(negedge ap_clk);
    cyc++;
    if (probe_out === 1'b1) probe_cnt++;
    if (kern_start === 1'b1 && ks_prev !== 1'b1) rise_cnt++;
    ks_prev = kern_start;
  endtask

  task automatic wait_start(output int s);
    int n;
    n = 0;
    while (kern_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("start_seen", kern_start, 1);
    s = cyc;
  endtask

  // One kernel invocation: ready one cycle after start, done 10 cycles after ready
  // (or ready+done together when same=1). Returns in the cycle after done.
  task automatic do_run(input bit same, input logic [31:0] w, output int s, output int d);
    wait_start(s);
    tick();
    check("start_held", kern_start, 1);
    kern_ready = 1'b1;
    d = cyc;
    if (same) begin
      kern_done   = 1'b1;
      E_out_write = 1'b1;
      E_out_din   = w;
      chk_m       = fold(chk_m, w);
    end
    tick();
    kern_ready  = 1'b0;
    kern_done   = 1'b0;
    E_out_write = 1'b0;
    check("start_drop", kern_start, 0);
    if (!same) begin
      E_out_write = 1'b1;
      E_out_din   = w;
      chk_m       = fold(chk_m, w);
      tick();
      E_out_write = 1'b0;
      repeat (8) tick();
      kern_done = 1'b1;
      d = cyc;
      tick();
      kern_done = 1'b0;
    end
  endtask

  initial begin
    int rel, s1, d1, s2, d2, s3, d3, n, window;
    logic [31:0] win_v;

    ap_rst_n    = 1'b0;
    kern_ready  = 1'b0;
    kern_done   = 1'b0;
    E_out_write = 1'b0;
    E_out_din   = '0;
    repeat (3) tick();
    check("rst_kern_start", kern_start, 0);
    check("rst_probe", probe_out, 0);
    check("rst_data_out", data_out, 4'h0);
    check("rst_data_valid", data_valid, 0);

    // Session 1: one full run, then reset while the second run is in WAIT.
    ap_rst_n = 1'b1;
    rel = cyc;
    do_run(1'b0, 32'h1, s1, d1);
    check("start_delay_1", s1 - rel, START_DLY);
    wait_start(s2);
    tick();
    kern_ready = 1'b1;
    tick();
    kern_ready = 1'b0;
    tick();
    tick();
    check("probe_in_wait", probe_out, 1);
    ap_rst_n = 1'b0;
    #1;
    check("arst_kern_start", kern_start, 0);
    check("arst_probe", probe_out, 0);
    check("arst_data_out", data_out, 4'h0);
    check("arst_data_valid", data_valid, 0);
    repeat (2) tick();

    // Session 2: clean three-run measurement; run 2 has ready and done together.
    chk_m     = '0;
    probe_cnt = 0;
    rise_cnt  = 0;
    ks_prev   = 1'b0;
    ap_rst_n  = 1'b1;
    rel = cyc;
    do_run(1'b0, 32'h1, s1, d1);
    check("start_delay_2", s1 - rel, START_DLY);
    do_run(1'b1, 32'h2, s2, d2);
    check("gap_after_wait", s2 - d1, 2);
    do_run(1'b0, 32'h4, s3, d3);
    check("gap_after_same", s3 - d2, 2);

    window = (d3 + 1) - s1 + 1;
    win_v  = window;
    for (int i = DATA_W / 4 - 1; i >= 0; i--) exp_q.push_back(chk_m[i*4 +: 4]);
`ifdef K2MM_CYCLE_REPORT_EN
    for (int i = CYC_W / 4 - 1; i >= 0; i--) exp_q.push_back(win_v[i*4 +: 4]);
`endif

    // First REPORT cycle: hammer the stream with ones; the snapshot must not move.
    tick();
    check("probe_off_report", probe_out, 0);
    check("valid_pre", data_valid, 0);
    E_out_write = 1'b1;
    E_out_din   = 32'hFFFF_FFFF;
    n = 0;
    while (data_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("first_valid_cyc", cyc, d3 + 3);
    n = 0;
    while (exp_q.size() > 0) begin
      check("nib_valid", data_valid, 1);
      check($sformatf("nibble_%0d", n), data_out, exp_q.pop_front());
      n++;
      tick();
    end
    E_out_write = 1'b0;
    check("valid_after_last", data_valid, 0);
    repeat (5) tick();
    check("halt_valid", data_valid, 0);
    check("probe_window", probe_cnt, window);
    check("run_count", rise_cnt, NUM_RUNS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
